// File: rtl/pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_chain
// Purpose  : Parametrised N-stage valid/allowin pipeline register chain.
//            Each stage holds one payload and has its own ready_go hold.
//            Bubbles collapse, so a held stage back-pressures only the
//            stages behind it. A synchronous flush clears every valid bit.
//            Occupancy is reported as a popcount of the per-stage valids.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH              payload width in bits (>=1)
//   DEPTH              number of register stages (>=1)
// Ports
//   clk_i              clock, rising edge
//   reset_i            asynchronous active-high reset
//   in_valid_i         upstream payload valid
//   in_data_i          upstream payload
//   in_allowin_o       chain accepts in_data_i this cycle
//   stage_ready_go_i   bit i: stage i may pass its payload on
//   flush_i            synchronous kill of every in-flight payload
//   out_valid_o        last stage presents a finished payload
//   out_data_o         payload of stage DEPTH-1
//   out_allowin_i      downstream accepts out_data_o
//   stage_valid_o      per-stage valid bits
//   occupancy_o        number of valid stages
//   stall_cycles_o     edges with out_valid_o && !out_allowin_i
//                      (only with PIPE_CHAIN_PERF_EN defined)
// Build option
//   PIPE_CHAIN_PERF_EN adds the stall_cycles_o counter and port
// ============================================================================
module pipe_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         in_valid_i,
   input  logic [WIDTH-1:0]             in_data_i,
   output logic                         in_allowin_o,
   input  logic [DEPTH-1:0]             stage_ready_go_i,
   input  logic                         flush_i,
   output logic                         out_valid_o,
   output logic [WIDTH-1:0]             out_data_o,
   input  logic                         out_allowin_i,
   output logic [DEPTH-1:0]             stage_valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
`ifdef PIPE_CHAIN_PERF_EN
   ,
   output logic [31:0]                  stall_cycles_o
`endif
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];

   logic [DEPTH-1:0] allowin;
   logic [DEPTH-1:0] to_next;
   logic [DEPTH-1:0] up_valid;
   logic [WIDTH-1:0] up_data [DEPTH];

   // Allowin ripples from the output back towards the input. A local
   // running value keeps the chain acyclic inside one process.
   always_comb begin : p_allowin
      logic downstream;
      downstream = out_allowin_i;
      allowin    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         downstream = !valid_q[i] || (stage_ready_go_i[i] && downstream);
         allowin[i] = downstream;
      end
   end

   assign to_next = valid_q & stage_ready_go_i;

   // What each stage sees from its upstream neighbour.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign up_valid[i] = in_valid_i;
         assign up_data[i]  = in_data_i;
      end else begin : g_body
         assign up_valid[i] = to_next[i-1];
         assign up_data[i]  = data_q[i-1];
      end
   end

   // Data is loaded regardless of flush: with valid cleared the stale
   // payload is invisible, so flush only needs to touch the valid bits.
   always_comb begin : p_next
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i] = data_q[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (allowin[i] && up_valid[i]) begin
            data_d[i] = up_data[i];
         end
         if (flush_i) begin
            valid_d[i] = 1'b0;
         end else if (allowin[i]) begin
            valid_d[i] = up_valid[i];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin : p_regs
      if (reset_i) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign in_allowin_o  = allowin[0];
   assign out_valid_o   = to_next[DEPTH-1];
   assign out_data_o    = data_q[DEPTH-1];
   assign stage_valid_o = valid_q;

   always_comb begin : p_occupancy
      occupancy_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy_o = occupancy_o + OCC_W'(valid_q[i]);
      end
   end

`ifdef PIPE_CHAIN_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] stall_d;

   // Counts wrap naturally at 2^32; flush leaves the count alone.
   assign stall_d = (out_valid_o && !out_allowin_i) ? stall_q + 32'd1 : stall_q;

   always_ff @(posedge clk_i or posedge reset_i) begin : p_stall
      if (reset_i) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles_o = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_chain
// Purpose  : Self-checking bench for pipe_chain. One 32x4 instance covers
//            streaming, backpressure, mid-stage hold, flush and async reset;
//            one 8x1 instance covers the single-stage case. A queue model
//            tracks every accepted payload and checks each one that leaves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_chain;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 32-bit x 4-stage instance
   logic        iv4 = 1'b0;
   logic [31:0] id4 = '0;
   logic        ia4;
   logic [3:0]  rg4 = 4'hF;
   logic        fl4 = 1'b0;
   logic        ov4;
   logic [31:0] od4;
   logic        oa4 = 1'b1;
   logic [3:0]  sv4;
   logic [2:0]  occ4;
`ifdef PIPE_CHAIN_PERF_EN
   logic [31:0] st4;
   logic [31:0] st1;
`endif

   // 8-bit x 1-stage instance
   logic        iv1 = 1'b0;
   logic [7:0]  id1 = '0;
   logic        ia1;
   logic [0:0]  rg1 = 1'b1;
   logic        fl1 = 1'b0;
   logic        ov1;
   logic [7:0]  od1;
   logic        oa1 = 1'b1;
   logic [0:0]  sv1;
   logic [0:0]  occ1;

   pipe_chain #(.WIDTH(32), .DEPTH(4)) u4 (
      .clk_i(clk), .reset_i(rst),
      .in_valid_i(iv4), .in_data_i(id4), .in_allowin_o(ia4),
      .stage_ready_go_i(rg4), .flush_i(fl4),
      .out_valid_o(ov4), .out_data_o(od4), .out_allowin_i(oa4),
      .stage_valid_o(sv4), .occupancy_o(occ4)
`ifdef PIPE_CHAIN_PERF_EN
      , .stall_cycles_o(st4)
`endif
   );

   pipe_chain #(.WIDTH(8), .DEPTH(1)) u1 (
      .clk_i(clk), .reset_i(rst),
      .in_valid_i(iv1), .in_data_i(id1), .in_allowin_o(ia1),
      .stage_ready_go_i(rg1), .flush_i(fl1),
      .out_valid_o(ov1), .out_data_o(od1), .out_allowin_i(oa1),
      .stage_valid_o(sv1), .occupancy_o(occ1)
`ifdef PIPE_CHAIN_PERF_EN
      , .stall_cycles_o(st1)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] q4[$];
   logic [7:0]  q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected no output at %0t", name, act, $time);
   endtask

   // Scoreboard step for the cycle in progress, then advance to the next
   // negedge where the caller drives new inputs.
   task automatic tick();
      logic [31:0] e4;
      logic [7:0]  e1;
      #1;
      if (ov4 && oa4) begin
         if (q4.size() == 0) unexpected("sb4_extra", od4);
         else begin
            e4 = q4.pop_front();
            chk("sb4_data", od4, e4);
         end
      end
      if (fl4) q4.delete();
      else if (iv4 && ia4) q4.push_back(id4);
      if (ov1 && oa1) begin
         if (q1.size() == 0) unexpected("sb1_extra", {24'h0, od1});
         else begin
            e1 = q1.pop_front();
            chk("sb1_data", {24'h0, od1}, {24'h0, e1});
         end
      end
      if (fl1) q1.delete();
      else if (iv1 && ia1) q1.push_back(id1);
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        exp_ia;
      logic        exp_ov;
      logic [31:0] exp_od;
      logic [2:0]  exp_occ;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Stream table: payload r+1 accepted at edge r (r<8) shows on the
      // output in row r+4; occupancy counts payloads from edges r-4..r-1.
      for (int r = 0; r < 13; r++) begin
         int lo, hi;
         lo = (r - 4 < 0) ? 0 : r - 4;
         hi = (r - 1 > 7) ? 7 : r - 1;
         tbl[r].iv      = (r < 8);
         tbl[r].id      = (r < 8) ? 32'(r + 1) : 32'h0;
         tbl[r].exp_ia  = 1'b1;
         tbl[r].exp_ov  = (r >= 4 && r <= 11);
         tbl[r].exp_od  = 32'(r - 3);
         tbl[r].exp_occ = (hi >= lo) ? 3'(hi - lo + 1) : 3'd0;
      end

      // ---------------- reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stage_valid", {28'h0, sv4}, 32'h0);
      chk("rst_occupancy",   {29'h0, occ4}, 32'h0);
      chk("rst_out_valid",   {31'h0, ov4}, 32'h0);
      chk("rst_out_data",    od4, 32'h0);
      chk("rst_in_allowin",  {31'h0, ia4}, 32'h1);
      chk("rst1_out_valid",  {31'h0, ov1}, 32'h0);
      chk("rst1_in_allowin", {31'h0, ia1}, 32'h1);
`ifdef PIPE_CHAIN_PERF_EN
      chk("rst_stall", st4, 32'h0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // ---------------- stream 0x1..0x8
      for (int r = 0; r < 13; r++) begin
         iv4 = tbl[r].iv; id4 = tbl[r].id; oa4 = 1'b1; rg4 = 4'hF;
         #1;
         chk("stream_in_allowin", {31'h0, ia4}, {31'h0, tbl[r].exp_ia});
         chk("stream_out_valid",  {31'h0, ov4}, {31'h0, tbl[r].exp_ov});
         chk("stream_occupancy",  {29'h0, occ4}, {29'h0, tbl[r].exp_occ});
         if (tbl[r].exp_ov) chk("stream_out_data", od4, tbl[r].exp_od);
         tick();
      end
      iv4 = 1'b0;

      // ---------------- backpressure
      oa4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         iv4 = 1'b1; id4 = 32'hA0 + 32'(k);
         tick();
      end
      iv4 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_in_allowin", {31'h0, ia4}, 32'h0);
         chk("bp_out_data",   od4, 32'hA0);
         chk("bp_occupancy",  {29'h0, occ4}, 32'h4);
         tick();
      end
      oa4 = 1'b1;
      #1;
      chk("bp_full_release_allowin", {31'h0, ia4}, 32'h1);
`ifdef PIPE_CHAIN_PERF_EN
      chk("bp_stall_cycles", st4, 32'h5);
`endif
      repeat (5) tick();
      chk("bp_drained_queue", 32'(q4.size()), 32'h0);
      chk("bp_drained_occ",   {29'h0, occ4}, 32'h0);

      // ---------------- mid-stage hold on stage 1
      for (int k = 0; k < 3; k++) begin
         iv4 = 1'b1; id4 = 32'hB0 + 32'(k);
         tick();
      end
      rg4 = 4'b1101; iv4 = 1'b1; id4 = 32'hB3;
      #1;
      chk("hold_in_allowin0", {31'h0, ia4}, 32'h0);
      chk("hold_stage_valid0", {28'h0, sv4}, 32'h7);
      tick();
      #1;
      chk("hold_stage_valid1", {28'h0, sv4}, 32'hB);
      chk("hold_out_data", od4, 32'hB0);
      chk("hold_in_allowin1", {31'h0, ia4}, 32'h0);
      tick();
      #1;
      chk("hold_stage_valid2", {28'h0, sv4}, 32'h3);
      tick();
      rg4 = 4'hF;
      #1;
      chk("hold_resume_allowin", {31'h0, ia4}, 32'h1);
      tick();
      iv4 = 1'b0;
      repeat (5) tick();
      chk("hold_drained_queue", 32'(q4.size()), 32'h0);

      // ---------------- flush with 3 in flight plus an offer
      for (int k = 0; k < 3; k++) begin
         iv4 = 1'b1; id4 = 32'hC0 + 32'(k);
         tick();
      end
      id4 = 32'hC3; fl4 = 1'b1;
      #1;
      chk("flush_pre_occ", {29'h0, occ4}, 32'h3);
      tick();
      fl4 = 1'b0; iv4 = 1'b0;
      #1;
      chk("flush_stage_valid", {28'h0, sv4}, 32'h0);
      chk("flush_occupancy",   {29'h0, occ4}, 32'h0);
      chk("flush_out_valid",   {31'h0, ov4}, 32'h0);
      repeat (6) tick();

      // ---------------- flush coinciding with an output transfer
      for (int k = 0; k < 4; k++) begin
         iv4 = 1'b1; id4 = 32'hD0 + 32'(k);
         tick();
      end
      iv4 = 1'b0; fl4 = 1'b1;
      #1;
      chk("flushout_out_valid", {31'h0, ov4}, 32'h1);
      chk("flushout_out_data", od4, 32'hD0);
      tick();
      fl4 = 1'b0;
      #1;
      chk("flushout_occupancy", {29'h0, occ4}, 32'h0);
      repeat (5) tick();

      // ---------------- DEPTH=1, out_allowin toggling
      iv1 = 1'b1; id1 = 8'h5A; oa1 = 1'b1;
      #1;
      chk("d1_accept_allowin", {31'h0, ia1}, 32'h1);
      tick();
      iv1 = 1'b0; oa1 = 1'b0;
      #1;
      chk("d1_out_valid_held", {31'h0, ov1}, 32'h1);
      chk("d1_out_data_held",  {24'h0, od1}, 32'h5A);
      chk("d1_full_blocked",   {31'h0, ia1}, 32'h0);
      tick();
      oa1 = 1'b1; iv1 = 1'b1; id1 = 8'hC3;
      #1;
      chk("d1_out_data_release", {24'h0, od1}, 32'h5A);
      chk("d1_lockstep_allowin", {31'h0, ia1}, 32'h1);
      tick();
      iv1 = 1'b0; oa1 = 1'b0;
      #1;
      chk("d1_second_data", {24'h0, od1}, 32'hC3);
      tick();
      oa1 = 1'b1;
      tick();
      #1;
      chk("d1_empty", {31'h0, ov1}, 32'h0);
      chk("d1_queue", 32'(q1.size()), 32'h0);

      // ---------------- asynchronous reset while full
      oa4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         iv4 = 1'b1; id4 = 32'hE0 + 32'(k);
         tick();
      end
      iv4 = 1'b0;
      #1;
      chk("areset_pre_full", {28'h0, sv4}, 32'hF);
      #1;
      rst = 1'b1;
      #1;
      chk("areset_stage_valid", {28'h0, sv4}, 32'h0);
      chk("areset_out_valid",   {31'h0, ov4}, 32'h0);
      chk("areset_in_allowin",  {31'h0, ia4}, 32'h1);
`ifdef PIPE_CHAIN_PERF_EN
      chk("areset_stall", st4, 32'h0);
`endif
      q4.delete();
      q1.delete();
      @(negedge clk);
      rst = 1'b0; oa4 = 1'b1;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
